mem_port_arbiter: RTL and testbench

Shares one single-port instruction/data memory between the fetch stage and the load/store path driven by decode (mem_read_en / mem_write_en). It arbitrates, issues one memory access at a time, waits a fixed memory latency, and returns a one-cycle ready pulse with read data to the winner. Data accesses have priority. A starvation limit guarantees fetch progress.

---
 rtl/mem_port_arbiter.sv | 159 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port memory between the fetch requester and the
//   load/store requester. It grants one access at a time, pulses mem_en for
//   one cycle, waits MEM_LATENCY cycles and then returns a one-cycle ready
//   pulse, with read data, to the requester that won. Data accesses have
//   priority. After STARVE_LIMIT consecutive data grants made while fetch was
//   waiting, fetch is forced through.
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   if_req/if_addr         fetch read request (level) and address
//   if_rdata/if_ready      fetch read data, valid during the if_ready pulse
//   d_read_en/d_write_en   load / store request (level); both high = store
//   d_addr/d_wdata         data address and store data
//   d_rdata/d_ready        load data, valid during the d_ready pulse
//   mem_en/mem_we          memory strobe (one cycle per access), write enable
//   mem_addr/mem_wdata     memory address / write data, held for the access
//   mem_rdata              memory read data
//   busy                   high whenever the arbiter is not idle
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_read_en,
  input  logic              d_write_en,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] CNT_INIT   = 4'(MEM_LATENCY - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t            state_q, state_d;
  logic              win_d_q, win_d_d;     // 1: data port owns the access
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        starve_q, starve_d;

  logic d_req;
  logic data_wins;

  always_comb begin
    state_d    = state_q;
    win_d_d    = win_d_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    cnt_d      = cnt_q;
    starve_d   = starve_q;
    d_req      = d_read_en | d_write_en;
    data_wins  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req | d_req) begin
          // Data wins unless fetch is waiting and has hit the starvation limit.
          data_wins = d_req & ~(if_req & (starve_q == STARVE_MAX));
          win_d_d   = data_wins;
          we_d      = data_wins & d_write_en;
          addr_d    = data_wins ? d_addr : if_addr;
          wdata_d   = d_wdata;
          if (data_wins & if_req) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + 4'd1;
          end else begin
            starve_d = '0;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_INIT;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // This edge is MEM_LATENCY cycles after the strobe: read data is valid.
          if (!win_d_q) begin
            if_rdata_d = mem_rdata;
          end else if (!we_q) begin
            d_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      win_d_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      cnt_q      <= '0;
      starve_q   <= '0;
    end else begin
      state_q    <= state_d;
      win_d_q    <= win_d_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      cnt_q      <= cnt_d;
      starve_q   <= starve_d;
    end
  end

  assign mem_en    = (state_q == ISSUE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ready  = (state_q == RESP) & ~win_d_q;
  assign d_ready   = (state_q == RESP) & win_d_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 and latency 3, both
// with starvation limit 4). A transaction-level model schedules each access
// from the arbitration rules and checks every output each cycle.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req     [2];
  logic [AW-1:0] if_addr    [2];
  logic [DW-1:0] if_rdata   [2];
  logic          if_ready   [2];
  logic          d_read_en  [2];
  logic          d_write_en [2];
  logic [AW-1:0] d_addr     [2];
  logic [DW-1:0] d_wdata    [2];
  logic [DW-1:0] d_rdata    [2];
  logic          d_ready    [2];
  logic          mem_en     [2];
  logic          mem_we     [2];
  logic [AW-1:0] mem_addr   [2];
  logic [DW-1:0] mem_wdata  [2];
  logic [DW-1:0] mem_rdata  [2];
  logic          busy       [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_port_arbiter #(
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .MEM_LATENCY (g == 0 ? 1 : 3),
      .STARVE_LIMIT(SL)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_rdata  (if_rdata[g]),
      .if_ready  (if_ready[g]),
      .d_read_en (d_read_en[g]),
      .d_write_en(d_write_en[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_rdata   (d_rdata[g]),
      .d_ready   (d_ready[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .busy      (busy[g])
    );
  end

  // Transaction model state (per instance)
  int          cyc;
  int          arb_c [2];   // next cycle in which the arbiter is idle
  int          en_c  [2];   // cycle of the expected mem_en strobe
  int          cap_c [2];   // cycle whose mem_rdata is captured
  int          rdy_c [2];   // cycle of the expected ready pulse
  int          starve[2];
  bit          win_d [2];
  bit          we_e  [2];
  logic [31:0] addr_e [2];
  logic [31:0] wdata_e[2];
  logic [31:0] cap_v  [2];
  logic [31:0] if_rd_e[2];
  logic [31:0] d_rd_e [2];
  bit          if_hold[2];
  bit          d_hold [2];
  int          n_tests;
  int          n_fails;
  bit          rec;
  byte         order_q[$];

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
    end
  endtask

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic reset_model();
    for (int k = 0; k < 2; k++) begin
      arb_c[k]   = cyc;
      en_c[k]    = -100;
      cap_c[k]   = -100;
      rdy_c[k]   = -100;
      starve[k]  = 0;
      win_d[k]   = 1'b0;
      we_e[k]    = 1'b0;
      addr_e[k]  = '0;
      wdata_e[k] = '0;
      cap_v[k]   = '0;
      if_rd_e[k] = '0;
      d_rd_e[k]  = '0;
      if_hold[k] = 1'b0;
      d_hold[k]  = 1'b0;
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      if_req[k]     = 1'b0;
      if_addr[k]    = '0;
      d_read_en[k]  = 1'b0;
      d_write_en[k] = 1'b0;
      d_addr[k]     = '0;
      d_wdata[k]    = '0;
      mem_rdata[k]  = $urandom;
    end
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, ".mem_en"},    k, 32'(mem_en[k]),   '0);
      chk({tag, ".mem_we"},    k, 32'(mem_we[k]),   '0);
      chk({tag, ".mem_addr"},  k, mem_addr[k],      '0);
      chk({tag, ".mem_wdata"}, k, mem_wdata[k],     '0);
      chk({tag, ".if_ready"},  k, 32'(if_ready[k]), '0);
      chk({tag, ".d_ready"},   k, 32'(d_ready[k]),  '0);
      chk({tag, ".if_rdata"},  k, if_rdata[k],      '0);
      chk({tag, ".d_rdata"},   k, d_rdata[k],       '0);
      chk({tag, ".busy"},      k, 32'(busy[k]),     '0);
    end
  endtask

  task automatic model_check(input int k);
    int L;
    bit idle, f, d, pick_d;
    L    = lat(k);
    idle = (cyc == arb_c[k]);
    chk("busy", k, 32'(busy[k]), 32'(!idle));
    if (idle) begin
      f = if_req[k];
      d = d_read_en[k] | d_write_en[k];
      if (f | d) begin
        pick_d = d && !(f && starve[k] == SL);
        if (pick_d && f) starve[k] = (starve[k] < SL) ? starve[k] + 1 : SL;
        else             starve[k] = 0;
        win_d[k]   = pick_d;
        we_e[k]    = pick_d && d_write_en[k];
        addr_e[k]  = pick_d ? d_addr[k] : if_addr[k];
        wdata_e[k] = d_wdata[k];
        en_c[k]    = cyc + 1;
        cap_c[k]   = cyc + 1 + L;
        rdy_c[k]   = cyc + 2 + L;
        arb_c[k]   = cyc + 3 + L;
      end else begin
        arb_c[k] = cyc + 1;
      end
    end
    if (cyc == cap_c[k]) cap_v[k] = mem_rdata[k];
    chk("mem_en", k, 32'(mem_en[k]), 32'(cyc == en_c[k]));
    if (cyc >= en_c[k] && cyc < rdy_c[k]) begin
      chk("mem_addr", k, mem_addr[k], addr_e[k]);
      chk("mem_we", k, 32'(mem_we[k]), 32'(we_e[k]));
      if (we_e[k]) chk("mem_wdata", k, mem_wdata[k], wdata_e[k]);
    end
    if (cyc == rdy_c[k]) begin
      if (win_d[k]) begin
        if (!we_e[k]) d_rd_e[k] = cap_v[k];
        d_hold[k] = 1'b0;
      end else begin
        if_rd_e[k] = cap_v[k];
        if_hold[k] = 1'b0;
      end
    end
    chk("if_ready", k, 32'(if_ready[k]), 32'(cyc == rdy_c[k] && !win_d[k]));
    chk("d_ready", k, 32'(d_ready[k]), 32'(cyc == rdy_c[k] && win_d[k]));
    chk("if_rdata", k, if_rdata[k], if_rd_e[k]);
    chk("d_rdata", k, d_rdata[k], d_rd_e[k]);
    if (rec && k == 0) begin
      if (if_ready[0]) order_q.push_back("F");
      if (d_ready[0])  order_q.push_back("D");
    end
  endtask

  // Check the current cycle at the falling edge, then advance to just after
  // the next rising edge with fresh garbage on mem_rdata.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 2; k++) model_check(k);
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) mem_rdata[k] = $urandom;
  endtask

  // Random requesters: a request is held until its ready pulse, then rerolled.
  task automatic agents(input bit allow_new);
    int r;
    for (int k = 0; k < 2; k++) begin
      if (!if_hold[k]) begin
        if_req[k]  = allow_new && ($urandom_range(0, 2) != 0);
        if_addr[k] = $urandom;
        if_hold[k] = if_req[k];
      end
      if (!d_hold[k]) begin
        r             = allow_new ? int'($urandom_range(0, 3)) : 0;
        d_read_en[k]  = (r == 1 || r == 3);
        d_write_en[k] = (r == 2 || r == 3);
        d_addr[k]     = $urandom;
        d_wdata[k]    = $urandom;
        d_hold[k]     = (r != 0);
      end
    end
  endtask

  initial begin
    string exp_order;
    int    c0;
    n_tests = 0;
    n_fails = 0;
    rec     = 1'b0;
    cyc     = 0;
    rst_n   = 1'b0;
    clear_inputs();
    reset_model();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc   = 0;
    reset_model();

    // 1: fetch alone, latency 1
    if_req[0]  = 1'b1;
    if_addr[0] = 32'h40;
    tick();
    tick();
    mem_rdata[0] = 32'h8C22_0004;
    tick();
    tick();
    if_req[0] = 1'b0;
    chk("t1.if_rdata", 0, if_rdata[0], 32'h8C22_0004);
    tick();

    // 2: store alone
    d_write_en[0] = 1'b1;
    d_addr[0]     = 32'h100;
    d_wdata[0]    = 32'hDEAD_BEEF;
    repeat (4) tick();
    d_write_en[0] = 1'b0;
    chk("t2.d_rdata", 0, d_rdata[0], 32'h0);
    tick();

    // 3: fetch and load held continuously
    if_req[0]    = 1'b1;
    if_addr[0]   = 32'h200;
    d_read_en[0] = 1'b1;
    d_addr[0]    = 32'h300;
    rec          = 1'b1;
    repeat (40) tick();
    rec          = 1'b0;
    if_req[0]    = 1'b0;
    d_read_en[0] = 1'b0;
    tick();
    exp_order = "DDDDFDDDDF";
    chk("t3.grants", 0, 32'(order_q.size()), 32'(exp_order.len()));
    for (int i = 0; i < exp_order.len() && i < order_q.size(); i++)
      chk("t3.order", i, 32'(order_q[i]), 32'(exp_order[i]));

    // 4: load on the latency-3 instance, valid data only in cycle 4
    d_read_en[1] = 1'b1;
    d_addr[1]    = 32'h80;
    repeat (4) tick();
    mem_rdata[1] = 32'h1234;
    tick();
    tick();
    d_read_en[1] = 1'b0;
    chk("t4.d_rdata", 1, d_rdata[1], 32'h1234);
    tick();

    // 5: read and write together act as a store
    d_read_en[0]  = 1'b1;
    d_write_en[0] = 1'b1;
    d_addr[0]     = 32'h104;
    d_wdata[0]    = 32'hA5A5_5A5A;
    repeat (4) tick();
    d_read_en[0]  = 1'b0;
    d_write_en[0] = 1'b0;
    tick();

    // Randomised traffic on both instances, then drain
    repeat (300) begin
      agents(1'b1);
      tick();
    end
    repeat (30) begin
      agents(1'b0);
      tick();
    end

    // 6: reset while the latency-3 instance is in WAIT
    if_req[1]  = 1'b1;
    if_addr[1] = 32'h44;
    c0 = cyc;
    tick();
    tick();
    chk("t6.pre", 1, 32'(cyc - c0), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6.async");
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("t6.held");
    rst_n = 1'b1;
    reset_model();
    repeat (10) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
